// File: rtl/thread_fetch_sched.sv
`default_nettype none
// ============================================================================
// thread_fetch_sched: two-thread round-robin fetch scheduler for the SIK stack CPU.
// Rev 1.0
// ============================================================================
module thread_fetch_sched #(
   parameter int          WIDTH    = 16,
   parameter int unsigned T0_START = 0,
   parameter int unsigned T1_START = 1,
   parameter int unsigned PC_STEP  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic             redirect_tid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             halt_req,
   input  logic             halt_tid,
   output logic             fetch_valid,
   output logic             fetch_tid,
   output logic [WIDTH-1:0] fetch_pc,
   output logic [1:0]       thread_halted,
   output logic             halt
);

   localparam logic [WIDTH-1:0] T0_INIT = T0_START[WIDTH-1:0];
   localparam logic [WIDTH-1:0] T1_INIT = T1_START[WIDTH-1:0];
   localparam logic [WIDTH-1:0] STEP    = PC_STEP[WIDTH-1:0];

   logic [WIDTH-1:0] pc0;
   logic [WIDTH-1:0] pc1;
   logic             last_tid;

   logic [1:0]       halted_next;
   logic [1:0]       eligible;
   logic             any_eligible;
   logic             sel;
   logic             redir0;
   logic             redir1;
   logic [WIDTH-1:0] eff_pc0;
   logic [WIDTH-1:0] eff_pc1;
   logic [WIDTH-1:0] sel_pc;
   logic [WIDTH-1:0] inc_pc;
   logic             do_fetch;
   logic [WIDTH-1:0] pc0_next;
   logic [WIDTH-1:0] pc1_next;

   // A halt request blocks the thread in the very cycle it arrives.
   always_comb begin
      halted_next = thread_halted;
      if (halt_req) begin
         halted_next[halt_tid] = 1'b1;
      end
   end

   // Redirects to halted threads are dropped, so a halted PC stays frozen.
   assign redir0 = redirect_valid && !redirect_tid && !halted_next[0];
   assign redir1 = redirect_valid &&  redirect_tid && !halted_next[1];

   assign eff_pc0 = redir0 ? redirect_pc : pc0;
   assign eff_pc1 = redir1 ? redirect_pc : pc1;

   assign eligible     = ~halted_next;
   assign any_eligible = |eligible;
   assign sel          = (&eligible) ? ~last_tid : eligible[1];

   assign sel_pc   = sel ? eff_pc1 : eff_pc0;
   assign inc_pc   = sel_pc + STEP;
   assign do_fetch = !stall && any_eligible;

   assign pc0_next = (do_fetch && !sel) ? inc_pc : eff_pc0;
   assign pc1_next = (do_fetch &&  sel) ? inc_pc : eff_pc1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc0           <= T0_INIT;
         pc1           <= T1_INIT;
         last_tid      <= 1'b1;
         thread_halted <= 2'b00;
         halt          <= 1'b0;
         fetch_valid   <= 1'b0;
         fetch_tid     <= 1'b0;
         fetch_pc      <= '0;
      end else begin
         thread_halted <= halted_next;
         halt          <= halt | (&thread_halted);
         pc0           <= pc0_next;
         pc1           <= pc1_next;
         if (do_fetch) begin
            fetch_valid <= 1'b1;
            fetch_tid   <= sel;
            fetch_pc    <= sel_pc;
            last_tid    <= sel;
         end else if (!stall) begin
            fetch_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
